traffic_counter: RTL and testbench

Phase sequencer and countdown for a two-way traffic-light intersection (north-south / east-west), clocked by the system's 1 Hz tick. On each tick it decrements the seconds remaining in the current phase and advances through the four phases. It drives the two-digit countdown display value and both directions' lamp outputs. It sits between the 1 Hz clock divider and the 7-segment and lamp drivers.

---
 rtl/traffic_counter_pkg.sv | 32 +++
 rtl/traffic_counter_if.sv | 14 +
 rtl/traffic_counter.sv | 61 ++++++
 tb/tb_traffic_counter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/traffic_counter_pkg.sv
// Shared types and constants for the intersection phase sequencer.
package traffic_pkg;

    // Intersection phases, in the order they are visited.
    typedef enum logic [1:0] {
        NS_GREEN  = 2'd0,
        NS_YELLOW = 2'd1,
        EW_GREEN  = 2'd2,
        EW_YELLOW = 2'd3
    } phase_t;

    // Lamp encodings, {red, yellow, green}, one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Largest duration the two-digit display can show.
    localparam int unsigned MAX_T = 99;

    // Phase that follows p; EW_YELLOW wraps back to NS_GREEN.
    function automatic phase_t next_phase(phase_t p);
        phase_t n;
        case (p)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            default:   n = NS_GREEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_counter_if.sv
// Display and lamp bundle from the phase sequencer to the downstream drivers.
// There is no handshake: every signal is continuously valid after reset and
// the consumer simply samples it; the producer never waits on the consumer.
interface traffic_counter_if;
    import traffic_pkg::*;

    logic [6:0] number;    // seconds remaining in the current phase, 1..99
    phase_t     phase;     // current phase (also the sequencer state)
    logic [2:0] ns_light;  // north-south {red, yellow, green}
    logic [2:0] ew_light;  // east-west {red, yellow, green}

    modport master (output number, output phase, output ns_light, output ew_light);
    modport slave  (input  number, input  phase, input  ns_light, input  ew_light);
endinterface

// File: rtl/traffic_counter.sv
// Two-way intersection phase sequencer with per-phase seconds countdown,
// advanced by the 1 Hz tick.
module traffic_counter
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_T  = 25,
    parameter int unsigned YELLOW_T = 3
) (
    input  logic               clk_1s,
    input  logic               rst,
    traffic_counter_if.master  tif
);

    // Reject durations the display or countdown cannot represent.
    if (GREEN_T < 1 || GREEN_T > MAX_T) begin : g_bad_green
        $error("traffic_counter: GREEN_T must be in 1..99");
    end
    if (YELLOW_T < 1 || YELLOW_T > MAX_T) begin : g_bad_yellow
        $error("traffic_counter: YELLOW_T must be in 1..99");
    end

    localparam logic [6:0] GREEN_D  = 7'(GREEN_T);
    localparam logic [6:0] YELLOW_D = 7'(YELLOW_T);

    phase_t     phase_q;
    logic [6:0] number_q;

    // Duration loaded on entry to phase p.
    function automatic logic [6:0] duration(phase_t p);
        return (p == NS_GREEN || p == EW_GREEN) ? GREEN_D : YELLOW_D;
    endfunction

    // Countdown and phase advance; reload at 1 so the display never shows 0.
    always_ff @(posedge clk_1s) begin
        if (rst) begin
            phase_q  <= NS_GREEN;
            number_q <= GREEN_D;
        end else if (number_q == 7'd1) begin
            phase_q  <= next_phase(phase_q);
            number_q <= duration(next_phase(phase_q));
        end else begin
            number_q <= number_q - 7'd1;
        end
    end

    assign tif.number = number_q;
    assign tif.phase  = phase_q;

    // Lamp decode from the phase alone; exactly one direction is non-red.
    always_comb begin
        tif.ns_light = LAMP_RED;
        tif.ew_light = LAMP_RED;
        case (phase_q)
            NS_GREEN:  tif.ns_light = LAMP_GRN;
            NS_YELLOW: tif.ns_light = LAMP_YEL;
            EW_GREEN:  tif.ew_light = LAMP_GRN;
            default:   tif.ew_light = LAMP_YEL;
        endcase
    end

endmodule

// File: tb/tb_traffic_counter.sv
// Self-checking bench for traffic_counter: default durations and the
// minimum-duration (1/1) corner case.
module tb_traffic_counter;
    import traffic_pkg::*;

    localparam int G = 25;
    localparam int Y = 3;
    localparam int CYCLE = 2 * (G + Y);

    // Clock and reset
    logic clk_1s = 1'b0;
    logic rst     = 1'b1;
    logic rst_min = 1'b1;
    always #5 clk_1s = ~clk_1s;

    traffic_counter_if tif();
    traffic_counter_if tif_min();

    traffic_counter dut (
        .clk_1s(clk_1s),
        .rst   (rst),
        .tif   (tif)
    );

    traffic_counter #(.GREEN_T(1), .YELLOW_T(1)) dut_min (
        .clk_1s(clk_1s),
        .rst   (rst_min),
        .tif   (tif_min)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard for the minimum-duration sequence
    logic [1:0] exp_q[$];

    typedef struct {
        int         edge_n;
        int         num;
        int         ph;
        logic [2:0] ns;
        logic [2:0] ew;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Independent reference: expected number/phase k edges after reset.
    task automatic model(input int k, output int num, output int ph);
        int t;
        t = k % CYCLE;
        if (t < G) begin
            ph = 0; num = G - t;
        end else if (t < G + Y) begin
            ph = 1; num = Y - (t - G);
        end else if (t < 2 * G + Y) begin
            ph = 2; num = G - (t - G - Y);
        end else begin
            ph = 3; num = Y - (t - 2 * G - Y);
        end
    endtask

    function automatic int exp_ns(int ph);
        case (ph)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_ew(int ph);
        case (ph)
            2:       return 1;
            3:       return 2;
            default: return 4;
        endcase
    endfunction

    // Per-edge checks against the model plus the safety invariants.
    task automatic check_edge(input int k);
        int num, ph;
        model(k, num, ph);
        check("seq_number", int'(tif.number), num);
        check("seq_phase", int'(tif.phase), ph);
        check("seq_ns", int'(tif.ns_light), exp_ns(ph));
        check("seq_ew", int'(tif.ew_light), exp_ew(ph));
        check("one_nonred", int'(tif.ns_light != LAMP_RED && tif.ew_light != LAMP_RED), 0);
        check("nonzero", int'(tif.number != 7'd0), 1);
    endtask

    task automatic tick();
        @(posedge clk_1s);
        #1;
    endtask

    initial begin
        int vi;
        vecs[0] = '{0,  25, 0, 3'b001, 3'b100};
        vecs[1] = '{24, 1,  0, 3'b001, 3'b100};
        vecs[2] = '{25, 3,  1, 3'b010, 3'b100};
        vecs[3] = '{28, 25, 2, 3'b100, 3'b001};
        vecs[4] = '{53, 3,  3, 3'b100, 3'b010};
        vecs[5] = '{56, 25, 0, 3'b001, 3'b100};

        // Reset, then a full cycle plus wrap, table checkpoints along the way
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vi = 0;
        for (int k = 0; k <= CYCLE; k++) begin
            if (k > 0) tick();
            check_edge(k);
            if (vi < 6 && vecs[vi].edge_n == k) begin
                check("tbl_number", int'(tif.number), vecs[vi].num);
                check("tbl_phase", int'(tif.phase), vecs[vi].ph);
                check("tbl_ns", int'(tif.ns_light), int'(vecs[vi].ns));
                check("tbl_ew", int'(tif.ew_light), int'(vecs[vi].ew));
                vi++;
            end
        end

        // Reset mid-operation at edge 30 (EW_GREEN)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k < 30; k++) tick();
        check("pre_mid_phase", int'(tif.phase), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_number", int'(tif.number), 25);
        check("mid_rst_phase", int'(tif.phase), 0);
        check("mid_rst_ns", int'(tif.ns_light), 1);
        check("mid_rst_ew", int'(tif.ew_light), 4);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_edge(k);
        end

        // Minimum durations: phase advances every edge, number stays 1
        rst_min = 1'b1;
        tick();
        rst_min = 1'b0;
        check("min_rst_number", int'(tif_min.number), 1);
        check("min_rst_phase", int'(tif_min.phase), 0);
        for (int i = 1; i <= 8; i++) exp_q.push_back(2'(i % 4));
        while (exp_q.size() > 0) begin
            logic [1:0] e;
            tick();
            e = exp_q.pop_front();
            check("min_phase", int'(tif_min.phase), int'(e));
            check("min_number", int'(tif_min.number), 1);
            check("min_one_nonred",
                  int'(tif_min.ns_light != LAMP_RED && tif_min.ew_light != LAMP_RED), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
